// File: rtl/sched_epoch_ctrl_if.sv
// sched_epoch_ctrl_if: bundles the scheduler handshake and the ingress transfer
// signals of sched_epoch_ctrl.
// master = epoch controller, slave = scheduler / dequeue datapath side.
interface sched_epoch_ctrl_if #(
    parameter int LEN_W = 4
);
    // scheduler handshake
    logic               sched_en;
    logic [3:0]         sched_sel_en;
    logic [7:0]         sched_sel;
    logic [4*LEN_W-1:0] pkt_slots;
    logic [3:0]         is_busy;
    logic [7:0]         busy_voq_num;
    // ingress transfer control
    logic [3:0]         xfer_en;
    logic [7:0]         xfer_voq;
    logic               slot_start;

    modport master (
        output sched_en, is_busy, busy_voq_num, xfer_en, xfer_voq, slot_start,
        input  sched_sel_en, sched_sel, pkt_slots
    );

    modport slave (
        input  sched_en, is_busy, busy_voq_num, xfer_en, xfer_voq, slot_start,
        output sched_sel_en, sched_sel, pkt_slots
    );
endinterface

// File: rtl/sched_epoch_ctrl.sv
// sched_epoch_ctrl: runs fixed epochs of a SCHED phase (sched_en pulse, fixed
// decision latency, grant sample) followed by a one-slot XFER phase, and keeps
// per-ingress remaining-slot counters so a multi-slot packet holds its VOQ.
// Optional feature macro: SCHED_EPOCH_STATS_EN adds o_grant_cnt / o_idle_epochs.
module sched_epoch_ctrl #(
    parameter int SCHED_LAT   = 6,
    parameter int SLOT_CYCLES = 16,
    parameter int LEN_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    sched_epoch_ctrl_if.master bus,
    output logic [15:0]        o_epoch_cnt
`ifdef SCHED_EPOCH_STATS_EN
    ,
    output logic [63:0]        o_grant_cnt,
    output logic [15:0]        o_idle_epochs
`endif
);

    localparam int CNT_MAX = (SCHED_LAT > SLOT_CYCLES - 1) ? SCHED_LAT : SLOT_CYCLES - 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCHED = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_sched_last;
    logic               w_xfer_last;

    logic               r_sched_en;
    logic               r_slot_start;
    logic [3:0]         r_xfer_en;
    logic [7:0]         r_xfer_voq;
    logic [3:0]         r_is_busy;
    logic [7:0]         r_busy_voq;
    logic [15:0]        r_epoch_cnt;
    logic [LEN_W-1:0]   r_rem [4];

    logic               w_sched_en;
    logic               w_slot_start;
    logic [3:0]         w_xfer_en;
    logic [7:0]         w_xfer_voq;
    logic [3:0]         w_is_busy;
    logic [7:0]         w_busy_voq;
    logic [15:0]        w_epoch_cnt;
    logic [LEN_W-1:0]   w_rem [4];
    logic [LEN_W-1:0]   w_pkt [4];

    // The grant-sampling edge closes the last SCHED cycle; the slot ends on the last XFER cycle.
    assign w_sched_last = (r_state == ST_SCHED) && (r_cnt == CNT_W'(SCHED_LAT));
    assign w_xfer_last  = (r_state == ST_XFER)  && (r_cnt == CNT_W'(SLOT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: run is only consulted in IDLE and on the last XFER cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_run) w_next_state = ST_SCHED;
                else       w_next_state = ST_IDLE;
            end
            ST_SCHED: begin
                if (w_sched_last) w_next_state = ST_XFER;
                else              w_next_state = ST_SCHED;
            end
            ST_XFER: begin
                if (w_xfer_last) w_next_state = i_run ? ST_SCHED : ST_IDLE;
                else             w_next_state = ST_XFER;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Phase cycle counter: restarts on every state change, idles at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_next_state != r_state) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == ST_IDLE) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Next values of the registered outputs and the per-ingress hold counters.
    always_comb begin
        w_sched_en   = (w_next_state == ST_SCHED) && (r_state != ST_SCHED);
        w_slot_start = w_sched_last;
        w_xfer_en    = r_xfer_en;
        w_xfer_voq   = r_xfer_voq;
        w_epoch_cnt  = r_epoch_cnt;
        w_busy_voq   = r_busy_voq;
        w_is_busy    = 4'b0000;

        if (w_sched_last) begin
            w_xfer_en  = bus.sched_sel_en;
            w_xfer_voq = bus.sched_sel;
        end else if (w_xfer_last) begin
            w_xfer_en  = 4'b0000;
            w_xfer_voq = 8'h00;
        end else begin
            w_xfer_en  = r_xfer_en;
            w_xfer_voq = r_xfer_voq;
        end

        if (w_xfer_last) w_epoch_cnt = r_epoch_cnt + 16'd1;
        else             w_epoch_cnt = r_epoch_cnt;

        for (int i = 0; i < 4; i++) begin
            w_rem[i] = r_rem[i];
            w_pkt[i] = bus.pkt_slots[i*LEN_W +: LEN_W];
            if (!w_sched_last) begin
                w_rem[i] = r_rem[i];
            end else if (bus.sched_sel_en[i] && (r_rem[i] == {LEN_W{1'b0}})) begin
                // New packet: a zero length counts as one slot, this slot included.
                if (w_pkt[i] == {LEN_W{1'b0}}) w_rem[i] = {LEN_W{1'b0}};
                else                           w_rem[i] = w_pkt[i] - LEN_W'(1);
                w_busy_voq[i*2 +: 2] = bus.sched_sel[i*2 +: 2];
            end else if (bus.sched_sel_en[i]) begin
                w_rem[i] = r_rem[i] - LEN_W'(1);
            end else begin
                // Ungranted ingress loses any packet in flight.
                w_rem[i] = {LEN_W{1'b0}};
            end
            w_is_busy[i] = (w_rem[i] != {LEN_W{1'b0}});
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sched_en   <= 1'b0;
            r_slot_start <= 1'b0;
            r_xfer_en    <= 4'b0000;
            r_xfer_voq   <= 8'h00;
            r_is_busy    <= 4'b0000;
            r_busy_voq   <= 8'h00;
            r_epoch_cnt  <= 16'h0000;
        end else begin
            r_sched_en   <= w_sched_en;
            r_slot_start <= w_slot_start;
            r_xfer_en    <= w_xfer_en;
            r_xfer_voq   <= w_xfer_voq;
            r_is_busy    <= w_is_busy;
            r_busy_voq   <= w_busy_voq;
            r_epoch_cnt  <= w_epoch_cnt;
        end
    end

    // Per-ingress remaining-slot counters; kept across IDLE so a pause keeps busy state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_rem[i] <= {LEN_W{1'b0}};
        end else begin
            for (int i = 0; i < 4; i++) r_rem[i] <= w_rem[i];
        end
    end

    assign bus.sched_en     = r_sched_en;
    assign bus.slot_start   = r_slot_start;
    assign bus.xfer_en      = r_xfer_en;
    assign bus.xfer_voq     = r_xfer_voq;
    assign bus.is_busy      = r_is_busy;
    assign bus.busy_voq_num = r_busy_voq;
    assign o_epoch_cnt      = r_epoch_cnt;

`ifdef SCHED_EPOCH_STATS_EN
    logic [63:0] r_grant_cnt;
    logic [15:0] r_idle_epochs;

    // Saturating grant and zero-grant epoch counters, updated on the first slot cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_cnt   <= 64'h0;
            r_idle_epochs <= 16'h0000;
        end else if (r_slot_start) begin
            for (int i = 0; i < 4; i++) begin
                if (r_xfer_en[i] && (r_grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
                end else begin
                    r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16];
                end
            end
            if ((r_xfer_en == 4'b0000) && (r_idle_epochs != 16'hFFFF)) begin
                r_idle_epochs <= r_idle_epochs + 16'd1;
            end else begin
                r_idle_epochs <= r_idle_epochs;
            end
        end else begin
            r_grant_cnt   <= r_grant_cnt;
            r_idle_epochs <= r_idle_epochs;
        end
    end

    assign o_grant_cnt   = r_grant_cnt;
    assign o_idle_epochs = r_idle_epochs;
`endif

endmodule

// File: tb/tb_sched_epoch_ctrl.sv
// tb_sched_epoch_ctrl: randomized scheduler model feeding sched_epoch_ctrl, with a
// scoreboard of expected per-slot results and a cycle monitor that compares them.
`timescale 1ns/1ps
module tb_sched_epoch_ctrl;
    localparam int SCHED_LAT   = 6;
    localparam int SLOT_CYCLES = 16;
    localparam int LEN_W       = 4;
    localparam int XFER_FIRST  = SCHED_LAT + 1;            // offset of slot_start from sched_en
    localparam int XFER_LAST   = SCHED_LAT + SLOT_CYCLES;  // offset of the last slot cycle

    typedef struct packed { logic [3:0] g; logic [7:0] sel; logic [15:0] pkt; } stim_t;
    typedef struct packed { logic [3:0] g; logic [7:0] sel; logic [3:0] busy; logic [7:0] bvoq; } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [15:0] epoch_cnt;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    sched_epoch_ctrl_if #(.LEN_W(LEN_W)) bus();

`ifdef SCHED_EPOCH_STATS_EN
    logic [63:0] grant_cnt;
    logic [15:0] idle_epochs;
`endif

    sched_epoch_ctrl #(.SCHED_LAT(SCHED_LAT), .SLOT_CYCLES(SLOT_CYCLES), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_run       (run),
        .bus         (bus),
        .o_epoch_cnt (epoch_cnt)
`ifdef SCHED_EPOCH_STATS_EN
        ,
        .o_grant_cnt   (grant_cnt),
        .o_idle_epochs (idle_epochs)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stim_t      stim_q[$];
    exp_t       exp_q[$];
    int         rem[4];
    logic [1:0] bvoq_m[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s @cyc %0d: event did not happen in time", name, cyc);
    endtask

    // Random scheduler decision that usually keeps busy ingresses on their VOQ.
    function automatic stim_t rand_stim();
        stim_t s;
        s.g   = 4'b0000;
        s.sel = 8'h00;
        s.pkt = 16'($urandom());
        for (int i = 0; i < 4; i++) begin
            if (rem[i] != 0 && $urandom_range(7, 0) != 0) begin
                s.g[i] = 1'b1;
                s.sel[2*i +: 2] = bvoq_m[i];
            end else begin
                s.g[i] = 1'($urandom_range(1, 0));
                s.sel[2*i +: 2] = 2'($urandom_range(3, 0));
            end
        end
        return s;
    endfunction

    // Scheduler model: answers each sched_en and pushes the expected slot outcome.
    stim_t s_cur;
    exp_t  e_new;
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin rem[i] = 0; bvoq_m[i] = 2'd0; end
            bus.sched_sel_en = 4'b0000;
            bus.sched_sel    = 8'h00;
            bus.pkt_slots    = 16'h0000;
        end else if (bus.sched_en) begin
            if (stim_q.size() > 0) s_cur = stim_q.pop_front();
            else                   s_cur = rand_stim();
            bus.sched_sel_en = s_cur.g;
            bus.sched_sel    = s_cur.sel;
            bus.pkt_slots    = s_cur.pkt;
            e_new.g   = s_cur.g;
            e_new.sel = s_cur.sel;
            for (int i = 0; i < 4; i++) begin
                int pk;
                pk = int'(s_cur.pkt[4*i +: 4]);
                if (s_cur.g[i]) begin
                    if (rem[i] == 0) begin
                        rem[i]    = ((pk < 1) ? 1 : pk) - 1;   // this slot is the first one
                        bvoq_m[i] = s_cur.sel[2*i +: 2];
                    end else begin
                        rem[i] = rem[i] - 1;
                    end
                end else begin
                    rem[i] = 0;
                end
                e_new.busy[i]         = (rem[i] != 0);
                e_new.bvoq[2*i +: 2]  = bvoq_m[i];
            end
            exp_q.push_back(e_new);
        end
    end

    // Monitor: tracks epoch position from sched_en and run, compares every cycle.
    bit          m_active = 1'b0;
    bit          m_launch = 1'b0;
    int          m_since = 0;
    bit          m_slot;
    bit          m_in_x;
    logic [15:0] exp_epoch = 16'h0000;
    logic [3:0]  exp_busy = 4'b0000;
    logic [7:0]  exp_bvoq = 8'h00;
    logic [3:0]  cur_g = 4'b0000;
    logic [7:0]  cur_sel = 8'h00;
    exp_t        e_pop;
`ifdef SCHED_EPOCH_STATS_EN
    int          m_gcnt[4];
    int          m_idle;
`endif
    always @(negedge clk) begin
        if (reset) begin
            m_active = 1'b0; m_launch = 1'b0; m_since = 0;
            exp_epoch = 16'h0000; exp_busy = 4'b0000; exp_bvoq = 8'h00;
            exp_q.delete();
`ifdef SCHED_EPOCH_STATS_EN
            for (int i = 0; i < 4; i++) m_gcnt[i] = 0;
            m_idle = 0;
`endif
        end else begin
            if (m_active) m_since++;
            if (m_launch) begin m_active = 1'b1; m_since = 0; end
            check("sched_en", 64'(bus.sched_en), 64'(m_launch));
            m_slot = m_active && (m_since == XFER_FIRST);
            check("slot_start", 64'(bus.slot_start), 64'(m_slot));
            if (m_slot) begin
                if (exp_q.size() == 0) begin
                    note_fail("scoreboard_empty");
                end else begin
                    e_pop = exp_q.pop_front();
                    cur_g = e_pop.g; cur_sel = e_pop.sel;
                    exp_busy = e_pop.busy; exp_bvoq = e_pop.bvoq;
                end
`ifdef SCHED_EPOCH_STATS_EN
                for (int i = 0; i < 4; i++) begin
                    check("grant_cnt", 64'(grant_cnt[16*i +: 16]), 64'(m_gcnt[i]));
                    if (cur_g[i]) m_gcnt[i]++;
                end
                check("idle_epochs", 64'(idle_epochs), 64'(m_idle));
                if (cur_g == 4'b0000) m_idle++;
`endif
            end
            m_in_x = m_active && (m_since >= XFER_FIRST) && (m_since <= XFER_LAST);
            check("xfer_en", 64'(bus.xfer_en), m_in_x ? 64'(cur_g) : 64'h0);
            if (m_in_x) check("xfer_voq", 64'(bus.xfer_voq), 64'(cur_sel));
            check("is_busy", 64'(bus.is_busy), 64'(exp_busy));
            check("busy_voq_num", 64'(bus.busy_voq_num), 64'(exp_bvoq));
            check("epoch_cnt", 64'(epoch_cnt), 64'(exp_epoch));
            if (m_active && m_since == XFER_LAST) begin
                exp_epoch = exp_epoch + 16'd1;
                m_launch  = run;
                if (!run) m_active = 1'b0;
            end else if (!m_active) begin
                m_launch = run;
            end else begin
                m_launch = 1'b0;
            end
        end
    end

    task automatic wait_slot();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.slot_start && n < 100) begin @(negedge clk); n++; end
        if (!bus.slot_start) note_fail("slot_timeout");
    endtask

    task automatic wait_sched(output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.sched_en && n < 100) begin @(negedge clk); n++; end
        if (!bus.sched_en) note_fail("sched_timeout");
        c = cyc;
    endtask

    int c0;
    int cp;
    int nw;
    initial begin
        reset = 1'b1;
        run   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sched_en",   64'(bus.sched_en),     64'h0);
        check("rst_xfer_en",    64'(bus.xfer_en),      64'h0);
        check("rst_xfer_voq",   64'(bus.xfer_voq),     64'h0);
        check("rst_is_busy",    64'(bus.is_busy),      64'h0);
        check("rst_busy_voq",   64'(bus.busy_voq_num), 64'h0);
        check("rst_slot_start", 64'(bus.slot_start),   64'h0);
        check("rst_epoch_cnt",  64'(epoch_cnt),        64'h0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Directed: ingress 0 single-slot grants, ingress 2 three-slot packet, then an empty grant.
        for (int k = 0; k < 3; k++) stim_q.push_back('{g: 4'b0001, sel: 8'h02, pkt: 16'h0001});
        for (int k = 0; k < 3; k++) stim_q.push_back('{g: 4'b0100, sel: 8'h30, pkt: 16'h0300});
        stim_q.push_back('{g: 4'b0000, sel: 8'h00, pkt: 16'h0000});
        run = 1'b1;
        c0  = cyc;
        wait_sched(cp); check("sched_en_t0", 64'(cp), 64'(c0 + 1));
        wait_sched(cp); check("sched_en_t1", 64'(cp), 64'(c0 + 24));
        wait_sched(cp); check("sched_en_t2", 64'(cp), 64'(c0 + 47));

        // Random epochs back to back.
        repeat (30) wait_slot();

        // Drop run in slot cycle 10; the slot completes and the block idles.
        wait_slot();
        repeat (9) @(posedge clk);
        #1 run = 1'b0;
        repeat (60) @(posedge clk);
        #1 run = 1'b1;
        repeat (15) wait_slot();

        // Async reset in slot cycle 5 while ingress 1 holds a 4-slot packet.
        stim_q.push_back('{g: 4'b0000, sel: 8'h00, pkt: 16'h0000});
        stim_q.push_back('{g: 4'b0010, sel: 8'h04, pkt: 16'h0040});
        nw = 0;
        while (stim_q.size() != 0 && nw < 200) begin @(posedge clk); nw++; end
        if (stim_q.size() != 0) note_fail("stim_timeout");
        wait_slot();
        check("busy_before_reset", 64'(bus.is_busy[1]), 64'h1);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_xfer_en",    64'(bus.xfer_en),      64'h0);
        check("async_is_busy",    64'(bus.is_busy),      64'h0);
        check("async_epoch_cnt",  64'(epoch_cnt),        64'h0);
        check("async_busy_voq",   64'(bus.busy_voq_num), 64'h0);
        check("async_slot_start", 64'(bus.slot_start),   64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        c0 = cyc;
        wait_sched(cp); check("sched_en_after_reset", 64'(cp), 64'(c0 + 1));
        repeat (5) wait_slot();
        @(posedge clk); #1 run = 1'b0;
        repeat (40) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
